// File: rtl/seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Drives NUM_DIGITS seven-segment digits from one shared BCD-to-segment decoder
// by time-multiplexing the digit selects. Each digit gets a slot of ON_CYCLES
// clocks. An optional guard gap of GUARD_CYCLES clocks follows each slot. During
// the gap all selects are off, which suppresses ghosting between digits.
//
// A new display value arrives through a valid/ready handshake into a one-deep
// pending buffer. The buffer is committed to the active value only at a frame
// boundary, so a single frame never mixes digits from two different values.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous, active-low reset
//   load_valid  in   a new display value is offered
//   load_value  in   4*NUM_DIGITS BCD nibbles, [3:0] = digit 0 (least significant)
//   load_ready  out  1 = pending buffer empty, an offer is accepted this cycle
//   blank_lz    in   1 = blank leading zeros (digit 0 is never blanked)
//   digit_code  out  nibble for the shared decoder, 4'hF = blank
//   digit_sel   out  one-hot active-high digit enable, all zero in the guard gap
//   frame_tick  out  1-cycle pulse in the frame commit cycle
//
// All outputs are registered. The output registers sample the scan state one
// cycle later, so after reset the scan state already points at slot 0. The
// first clock edge therefore shows digit_sel = 1 for a full ON_CYCLES slot.
// frame_tick is visible in the last cycle of a frame. The edge that ends that
// cycle commits the pending value, and the same edge loads digit 0 of the new
// frame.
// -----------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic                    load_ready,
    input  logic                    blank_lz,
    output logic [3:0]              digit_code,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_tick
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        S_ON,
        S_GUARD
    } state_t;

    // Scan state
    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        count_reg, count_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic                    wrap;
    logic                    advance;

    // Display value storage
    logic [4*NUM_DIGITS-1:0] active_reg, active_next;
    logic [4*NUM_DIGITS-1:0] pending_reg;
    logic                    load_ready_reg;   // 1 = pending buffer empty

    // Output registers
    logic [NUM_DIGITS-1:0]   digit_sel_reg, digit_sel_next;
    logic [3:0]              digit_code_reg, digit_code_next;
    logic                    frame_tick_reg;

    logic                    commit;
    logic                    xfer;
    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   upper_zero;       // digit i and every digit above it are 0
    logic                    blanked;

    // -------------------------------------------------------------------------
    // Slot sequencing: ON -> (GUARD) -> next slot, wrap after the top digit
    // -------------------------------------------------------------------------
    always_comb begin : scan_next
        state_next = state_reg;
        idx_next   = idx_reg;
        count_next = count_reg + 1'b1;
        wrap       = 1'b0;
        advance    = 1'b0;
        case (state_reg)
            S_ON: begin
                if (count_reg == ON_LAST) begin
                    count_next = '0;
                    if (GUARD_CYCLES > 0) begin
                        state_next = S_GUARD;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_GUARD: begin
                if (count_reg == GUARD_LAST) begin
                    count_next = '0;
                    state_next = S_ON;
                    advance    = 1'b1;
                end
            end
            default: begin
                state_next = S_ON;
                count_next = '0;
            end
        endcase
        if (advance) begin
            if (idx_reg == IDX_LAST) begin
                idx_next = '0;
                wrap     = 1'b1;
            end else begin
                idx_next = idx_reg + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Handshake and commit. The two never change pending in the same cycle:
    // a commit needs a full buffer, and a transfer needs an empty one.
    // -------------------------------------------------------------------------
    assign commit      = frame_tick_reg && !load_ready_reg;
    assign xfer        = load_valid && load_ready_reg;
    assign active_next = commit ? pending_reg : active_reg;

    // The digit code is built from active_next. That way digit 0 of a new
    // frame, which loads on the commit edge, already shows the committed value.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib[gi] = active_next[4*gi +: 4];
        end
    endgenerate

    always_comb begin : lz_scan
        logic all_zero;
        all_zero   = 1'b1;
        upper_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero      = all_zero && (nib[i] == 4'h0);
            upper_zero[i] = all_zero;
        end
    end

    assign blanked = blank_lz && (idx_reg != '0) && upper_zero[idx_reg];

    always_comb begin : out_next
        digit_sel_next  = '0;
        digit_code_next = 4'hF;
        if (state_reg == S_ON) begin
            digit_sel_next[idx_reg] = 1'b1;
            digit_code_next         = blanked ? 4'hF : nib[idx_reg];
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_ON;
            count_reg      <= '0;
            idx_reg        <= '0;
            active_reg     <= '0;
            pending_reg    <= '0;
            load_ready_reg <= 1'b1;
            digit_sel_reg  <= '0;
            digit_code_reg <= 4'hF;
            frame_tick_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            idx_reg        <= idx_next;
            active_reg     <= active_next;
            digit_sel_reg  <= digit_sel_next;
            digit_code_reg <= digit_code_next;
            frame_tick_reg <= wrap;
            if (xfer) begin
                pending_reg    <= load_value;
                load_ready_reg <= 1'b0;
            end else if (commit) begin
                load_ready_reg <= 1'b1;
            end
        end
    end

    assign load_ready = load_ready_reg;
    assign digit_sel  = digit_sel_reg;
    assign digit_code = digit_code_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed testbench for seven_seg_scan_ctrl with NUM_DIGITS=4, ON_CYCLES=4 and
// GUARD_CYCLES=1, which gives a 20-cycle frame.
// Cycle k counts rising edges since reset release, and outputs are sampled on
// the falling edge after edge k. Frames cover k = 1..20, 21..40 and so on.
// Within a frame, pos = (k-1)%20, the slot is pos/5, and pos%5 == 4 is the
// guard cycle.
// frame_tick is expected at pos 19.
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_value = 16'h0;
    logic        load_ready;
    logic        blank_lz = 1'b1;
    logic [3:0]  digit_code;
    logic [3:0]  digit_sel;
    logic        frame_tick;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .ON_CYCLES   (4),
        .GUARD_CYCLES(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_value(load_value),
        .load_ready(load_ready),
        .blank_lz  (blank_lz),
        .digit_code(digit_code),
        .digit_sel (digit_sel),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          k        = 0;
    int          offer_start_k = 0;
    logic [15:0] offer_q [$];
    int          acc_k   [$];
    logic        ready_prev = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    // Advance to the next falling edge and maintain the load handshake. An
    // offer that saw ready at the previous sample has transferred on the edge
    // in between.
    task automatic cyc();
        @(negedge clk);
        k++;
        if (load_valid && ready_prev) begin
            acc_k.push_back(k - 1);
            $display("load %h accepted in cycle %0d", offer_q[0], k - 1);
            void'(offer_q.pop_front());
        end
        if (offer_q.size() > 0 && k >= offer_start_k) begin
            load_valid = 1'b1;
            load_value = offer_q[0];
        end else begin
            load_valid = 1'b0;
        end
        ready_prev = load_ready;
    endtask

    // Run one full frame and check selects, codes and tick in every cycle.
    // exp_codes holds the expected code per digit, with [3:0] = digit 0.
    task automatic run_frame(input string tag, input logic [15:0] exp_codes);
        for (int i = 0; i < 20; i++) begin
            int pos;
            int slot;
            logic [3:0] e_sel;
            logic [3:0] e_code;
            cyc();
            pos    = (k - 1) % 20;
            slot   = pos / 5;
            e_sel  = (pos % 5 < 4) ? (4'b0001 << slot) : 4'b0000;
            e_code = (pos % 5 < 4) ? exp_codes[4*slot +: 4] : 4'hF;
            check({tag, "_sel"},  32'(digit_sel),  32'(e_sel));
            check({tag, "_code"}, 32'(digit_code), 32'(e_code));
            check({tag, "_tick"}, 32'(frame_tick), 32'(pos == 19));
        end
        $display("frame %s done at cycle %0d", tag, k);
    endtask

    initial begin
        // Power-up reset
        repeat (2) @(negedge clk);
        check("rst_sel",   32'(digit_sel),  32'h0);
        check("rst_code",  32'(digit_code), 32'hF);
        check("rst_ready", 32'(load_ready), 32'h1);
        check("rst_tick",  32'(frame_tick), 32'h0);
        rst_n = 1'b1;
        k = 0;

        // Idle scan, active value 0 with blanking: shows 0,F,F,F
        run_frame("idle1", 16'hFFF0);
        run_frame("idle2", 16'hFFF0);

        // Mid-frame load of 1234, committed only at the frame boundary
        offer_q.push_back(16'h1234);
        offer_start_k = 45;
        run_frame("hold1234", 16'hFFF0);
        check("ready_full", 32'(load_ready), 32'h0);
        offer_q.push_back(16'h0050);
        offer_start_k = 65;
        run_frame("show1234", 16'h1234);

        // Leading-zero blanking on and off with 0050
        run_frame("lz_on", 16'hFF50);
        blank_lz = 1'b0;
        run_frame("lz_off", 16'h0050);
        blank_lz = 1'b1;

        // Backpressure: two offers in one frame
        offer_q.push_back(16'h1111);
        offer_q.push_back(16'h2222);
        offer_start_k = 123;
        run_frame("bp_old", 16'hFF50);
        check("bp_ready", 32'(load_ready), 32'h0);
        run_frame("bp_1111", 16'h1111);

        // Offer on the commit cycle (k=180) with pending empty. The nibble C is
        // above 9 and must pass through unchanged.
        offer_q.push_back(16'h00C7);
        offer_start_k = 180;
        run_frame("bp_2222", 16'h2222);
        run_frame("edge_old", 16'h2222);
        check("edge_ready", 32'(load_ready), 32'h0);
        run_frame("edge_new", 16'hFFC7);

        // Reset mid-slot with a value pending
        offer_q.push_back(16'h9999);
        offer_start_k = 221;
        cyc();
        cyc();
        check("pre_rst_sel",   32'(digit_sel),  32'h1);
        check("pre_rst_code",  32'(digit_code), 32'h7);
        check("pre_rst_ready", 32'(load_ready), 32'h0);
        #1 rst_n = 1'b0;
        #1;
        check("async_sel",   32'(digit_sel),  32'h0);
        check("async_code",  32'(digit_code), 32'hF);
        check("async_ready", 32'(load_ready), 32'h1);
        check("async_tick",  32'(frame_tick), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        ready_prev = load_ready;
        // Active and pending are lost, so both frames show 0 again
        run_frame("post_rst1", 16'hFFF0);
        run_frame("post_rst2", 16'hFFF0);

        // Acceptance cycles: 1234@45, 0050@65, 1111@123, 2222@141
        // (one after the tick at 140), 00C7@180, 9999@221
        check("acc_count", 32'(acc_k.size()), 32'd6);
        if (acc_k.size() == 6) begin
            check("acc_1234", 32'(acc_k[0]), 32'd45);
            check("acc_0050", 32'(acc_k[1]), 32'd65);
            check("acc_1111", 32'(acc_k[2]), 32'd123);
            check("acc_2222", 32'(acc_k[3]), 32'd141);
            check("acc_00C7", 32'(acc_k[4]), 32'd180);
            check("acc_9999", 32'(acc_k[5]), 32'd221);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
